pe_window_region: RTL

- Per-pixel window-membership generator for the priority-evaluation pipeline.
- Tracks the current pixel coordinate and compares it against the WIN0/WIN1 rectangle registers, which are shadowed once per scanline.
- Emits registered, priority-resolved WIN0/WIN1/OBJ-window flags that feed the window masker directly downstream.
- One pixel per pixel_en strobe; fixed one-cycle latency.

---
 rtl/pe_window_region.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pe_window_region.sv
// Per-pixel WIN0/WIN1/OBJ-window membership for the priority-evaluation pipeline.
// Window rectangles are shadowed at each line/frame start; flags are registered, one-cycle latency.
module pe_window_region #(
   parameter int unsigned H_PIXELS = 240,
   parameter int unsigned V_LINES  = 160,
   parameter int unsigned Y_MAX    = 227
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        line_start,
   input  logic        pixel_en,
   input  logic        objwin_in,
   input  logic [15:0] WIN0H,
   input  logic [15:0] WIN1H,
   input  logic [15:0] WIN0V,
   input  logic [15:0] WIN1V,
   input  logic [15:0] DISPCNT,
   output logic        WIN0,
   output logic        WIN1,
   output logic        obj,
   output logic        pix_valid,
   output logic [7:0]  pix_x,
   output logic [7:0]  pix_y
);

   localparam logic [7:0] HLim = 8'(H_PIXELS);
   localparam logic [7:0] VLim = 8'(V_LINES);
   localparam logic [7:0] YMax = 8'(Y_MAX);

   // End is clamped to the limit first; start > end means the window wraps around the edge.
   function automatic logic in_range(input logic [7:0] a, input logic [7:0] b_in,
                                     input logic [7:0] c, input logic [7:0] lim);
      logic [7:0] b;
      b = (b_in > lim) ? lim : b_in;
      if (a < b)      return (c >= a) && (c < b);
      else if (a > b) return (c >= a) || (c < b);
      else            return 1'b0;
   endfunction

   logic [7:0]  x_q, x_d, y_q, y_d;
   logic [15:0] win0h_q, win0h_d, win1h_q, win1h_d;
   logic [2:0]  en_q, en_d;
   logic        vin0_q, vin0_d, vin1_q, vin1_d;
   logic        win0_q, win0_d, win1_q, win1_d, obj_q, obj_d;
   logic        valid_q, valid_d;
   logic [7:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic        load, accept, hin0, hin1;

   logic unused_dispcnt;
   assign unused_dispcnt = ^DISPCNT[12:0];

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      load   = 1'b0;
      accept = 1'b0;
      if (frame_start) begin
         x_d  = 8'd0;
         y_d  = 8'd0;
         load = 1'b1;
      end else if (line_start) begin
         x_d  = 8'd0;
         y_d  = (y_q >= YMax) ? YMax : y_q + 8'd1;
         load = 1'b1;
      end else if (pixel_en && (x_q < HLim) && (y_q < VLim)) begin
         accept = 1'b1;
         x_d    = x_q + 8'd1;
      end
   end

   // Vertical membership is resolved once per line against the new y.
   always_comb begin
      win0h_d = win0h_q;
      win1h_d = win1h_q;
      en_d    = en_q;
      vin0_d  = vin0_q;
      vin1_d  = vin1_q;
      if (load) begin
         win0h_d = WIN0H;
         win1h_d = WIN1H;
         en_d    = DISPCNT[15:13];
         vin0_d  = in_range(WIN0V[15:8], WIN0V[7:0], y_d, VLim);
         vin1_d  = in_range(WIN1V[15:8], WIN1V[7:0], y_d, VLim);
      end
   end

   always_comb begin
      hin0    = in_range(win0h_q[15:8], win0h_q[7:0], x_q, HLim);
      hin1    = in_range(win1h_q[15:8], win1h_q[7:0], x_q, HLim);
      win0_d  = accept & en_q[0] & vin0_q & hin0;
      win1_d  = accept & en_q[1] & vin1_q & hin1 & ~win0_d;
      obj_d   = accept & en_q[2] & objwin_in & ~win0_d & ~win1_d;
      valid_d = accept;
      pix_x_d = accept ? x_q : pix_x_q;
      pix_y_d = accept ? y_q : pix_y_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_q     <= 8'd0;
         y_q     <= 8'd0;
         win0h_q <= 16'd0;
         win1h_q <= 16'd0;
         en_q    <= 3'd0;
         vin0_q  <= 1'b0;
         vin1_q  <= 1'b0;
         win0_q  <= 1'b0;
         win1_q  <= 1'b0;
         obj_q   <= 1'b0;
         valid_q <= 1'b0;
         pix_x_q <= 8'd0;
         pix_y_q <= 8'd0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         win0h_q <= win0h_d;
         win1h_q <= win1h_d;
         en_q    <= en_d;
         vin0_q  <= vin0_d;
         vin1_q  <= vin1_d;
         win0_q  <= win0_d;
         win1_q  <= win1_d;
         obj_q   <= obj_d;
         valid_q <= valid_d;
         pix_x_q <= pix_x_d;
         pix_y_q <= pix_y_d;
      end
   end

   assign WIN0      = win0_q;
   assign WIN1      = win1_q;
   assign obj       = obj_q;
   assign pix_valid = valid_q;
   assign pix_x     = pix_x_q;
   assign pix_y     = pix_y_q;

endmodule
